// File: rtl/vedic_multiplier_4x4_using_2x2.sv
// vedic_multiplier_4x4_using_2x2
// Registered 4x4 unsigned multiplier in Urdhva-Tiryagbhyam (Vedic) style.
// The operands are split into 2-bit halves and four 2x2 Vedic cells form the
// partial products Q0..Q3. Three ripple adders built from half/full adders
// then merge them into the 8-bit product, which is registered once.
//
// Ports:
//   clk       rising-edge clock for all state
//   rst_n     asynchronous active-low reset (clears product and out_valid)
//   in_valid  A/B carry a new operand pair this cycle
//   A, B      4-bit unsigned multiplicand / multiplier
//   product   registered 8-bit A*B, held while no new pair arrives
//   out_valid product holds a result captured on the previous in_valid cycle
module vedic_multiplier_4x4_using_2x2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] product,
  output logic       out_valid
);

  // Half adder, returned as {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // Full adder, returned as {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  // 2x2 Vedic cell: vertical product on bit 0, crosswise products summed by a
  // half adder for bit 1, then the left vertical product plus that carry
  // gives bits 3:2.
  function automatic logic [3:0] vedic_2x2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] h1;
    logic [1:0] h2;
    h1 = half_add(a[1] & b[0], a[0] & b[1]);
    h2 = half_add(a[1] & b[1], h1[1]);
    return {h2[1], h2[0], h1[0], a[0] & b[0]};
  endfunction

  // 4-bit ripple adder that keeps its carry-out as bit 4.
  function automatic logic [4:0] ripple_add4c(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] s;
    logic [1:0] st;
    logic       c;
    st   = half_add(x[0], y[0]);
    s[0] = st[0];
    c    = st[1];
    for (int i = 1; i < 4; i++) begin
      st   = full_add(x[i], y[i], c);
      s[i] = st[0];
      c    = st[1];
    end
    return {c, s};
  endfunction

  // 5-bit ripple adder; the final carry is dropped because the operands fed
  // here can never overflow five bits.
  function automatic logic [4:0] ripple_add5(input logic [4:0] x, input logic [4:0] y);
    logic [4:0] s;
    logic [1:0] st;
    logic       c;
    c = 1'b0;
    for (int i = 0; i < 5; i++) begin
      st   = full_add(x[i], y[i], c);
      s[i] = st[0];
      c    = st[1];
    end
    return s;
  endfunction

  // 4-bit ripple adder without carry-out; used for the top nibble, whose sum
  // is bounded by 225 >> 4 = 14 and so never carries out.
  function automatic logic [3:0] ripple_add4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] s;
    logic [1:0] st;
    logic       c;
    c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      st   = full_add(x[i], y[i], c);
      s[i] = st[0];
      c    = st[1];
    end
    return s;
  endfunction

  logic [3:0] q0;
  logic [3:0] q1;
  logic [3:0] q2;
  logic [3:0] q3;
  logic [4:0] s1;
  logic [4:0] s2;
  logic [3:0] s3;
  logic [7:0] result;

  // Combinational product: four 2x2 cells give the partial products, the
  // two middle (weight 4) terms are summed, the upper half of Q0 is folded
  // in, and whatever spills above bit 3 joins Q3 in the top nibble.
  always_comb begin
    q0     = vedic_2x2(A[1:0], B[1:0]);
    q1     = vedic_2x2(A[3:2], B[1:0]);
    q2     = vedic_2x2(A[1:0], B[3:2]);
    q3     = vedic_2x2(A[3:2], B[3:2]);
    s1     = ripple_add4c(q1, q2);
    s2     = ripple_add5(s1, {3'b000, q0[3:2]});
    s3     = ripple_add4(q3, {1'b0, s2[4:2]});
    result = {s3, s2[1:0], q0[1:0]};
  end

  // Output register: capture on in_valid, otherwise hold the product and
  // drop out_valid. Reset clears both immediately and discards any pair
  // that was waiting to be captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product   <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        product <= result;
      end
    end
  end

endmodule

// File: tb/tb_vedic_multiplier_4x4_using_2x2.sv
// tb_vedic_multiplier_4x4_using_2x2
// Scoreboard bench for the registered 4x4 Vedic multiplier. The driver pushes
// the arithmetic product of every pair it presents with in_valid into a queue;
// an independent monitor pops and compares whenever out_valid is high, and
// also checks that out_valid follows the previous cycle's in_valid.
module tb_vedic_multiplier_4x4_using_2x2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic [7:0] product;
  logic       out_valid;

  int         passCount = 0;
  int         checkCount = 0;
  logic [7:0] expQ[$];
  bit         monEn = 1'b0;

  always #5 clk = ~clk;

  vedic_multiplier_4x4_using_2x2 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .product   (product),
    .out_valid (out_valid)
  );

  // One comparison: count it, and report actual vs required on a miss.
  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Drive a pair on the falling edge, then at the capturing rising edge
  // record the expected product if the DUT will accept it.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic v);
    logic [7:0] expProd;
    @(negedge clk);
    A        = a;
    B        = b;
    in_valid = v;
    @(posedge clk);
    if (v && rst_n) begin
      expProd = 8'(int'(a) * int'(b));
      expQ.push_back(expProd);
    end
  endtask

  // Monitor: out_valid must mirror the in_valid seen at the previous edge,
  // and every valid product is matched against the scoreboard head.
  initial begin
    logic       sampledValid;
    logic [7:0] expProd;
    forever begin
      @(posedge clk);
      sampledValid = in_valid && rst_n;
      #1;
      if (monEn) begin
        checkOutput("out_valid", {7'b0, out_valid}, {7'b0, sampledValid});
        if (out_valid) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_output", 8'd1, 8'd0);
          end else begin
            expProd = expQ.pop_front();
            checkOutput("product", product, expProd);
          end
        end
      end
    end
  end

  // Directed and corner pairs with the products written out by hand.
  logic [3:0] dirA[9] = '{4'd4, 4'd6, 4'd4, 4'd11, 4'd6, 4'd15, 4'd0, 4'd1, 4'd8};
  logic [3:0] dirB[9] = '{4'd12, 4'd14, 4'd8, 4'd12, 4'd15, 4'd15, 4'd9, 4'd13, 4'd8};
  logic [7:0] dirP[9] = '{8'd48, 8'd84, 8'd32, 8'd132, 8'd90, 8'd225, 8'd0, 8'd13, 8'd64};

  // Main sequence: reset, directed, hold, exhaustive, random, reset mid-stream.
  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    A        = 4'd0;
    B        = 4'd0;

    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_product", product, 8'h00);
    checkOutput("reset_out_valid", {7'b0, out_valid}, 8'h00);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    monEn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(4'd0, 4'd0, 1'b0);
      #1;
      checkOutput("post_release_product", product, 8'h00);
    end

    for (int i = 0; i < 9; i++) begin
      applyStimulus(dirA[i], dirB[i], 1'b1);
      #1;
      checkOutput("directed_product", product, dirP[i]);
    end

    applyStimulus(4'd7, 4'd9, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'($urandom_range(15)), 4'($urandom_range(15)), 1'b0);
      #1;
      checkOutput("hold_product", product, 8'd63);
    end

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        applyStimulus(4'(a), 4'(b), 1'b1);
      end
    end

    for (int i = 0; i < 60; i++) begin
      applyStimulus(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
    end

    @(negedge clk);
    A        = 4'd11;
    B        = 4'd12;
    in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_product", product, 8'h00);
    checkOutput("midreset_out_valid", {7'b0, out_valid}, 8'h00);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(4'($urandom_range(15)), 4'($urandom_range(15)), 1'b0);
      #1;
      checkOutput("midreset_discard", product, 8'h00);
    end

    applyStimulus(4'd0, 4'd0, 1'b0);
    #2;
    checkOutput("scoreboard_drained", 8'(expQ.size()), 8'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
